// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types, ID/EX register layout and immediate helpers
package rv32i_types;

    localparam int RV_XLEN = 32;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } opcode_t;

    typedef struct packed {
        opcode_t    opcode;
        logic [3:0] alu_op;
        logic       use_rs1;
        logic       use_rs2;
        logic       load_regfile;
        logic       dmem_read;
        logic       dmem_write;
        logic       jal;
        logic       jalr;
    } rv32i_control_word;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        rv32i_control_word  ctrl;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [RV_XLEN-1:0] rs1_data;
        logic [RV_XLEN-1:0] rs2_data;
        logic [RV_XLEN-1:0] imm;
    } id_ex_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Format is chosen by the raw opcode bits; unknown opcodes yield zero.
    function automatic logic [31:0] decode_imm(input logic [31:0] instr);
        case (instr[6:0])
            op_imm, op_load, op_jalr: return imm_i(instr);
            op_store:                 return imm_s(instr);
            op_br:                    return imm_b(instr);
            op_lui, op_auipc:         return imm_u(instr);
            op_jal:                   return imm_j(instr);
            default:                  return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
    import rv32i_types::*;
(
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  rv32i_control_word id_ctrl,
    input  logic              ex_valid,
    input  rv32i_control_word ex_ctrl,
    input  logic [4:0]        ex_rd,
    output logic              hazard
);

    logic rs1_hit;
    logic rs2_hit;

    // A load in EX whose destination is read by the ID instruction cannot forward in time.
    always_comb begin
        rs1_hit = id_ctrl.use_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_ctrl.use_rs2 && (id_rs2 == ex_rd);
        hazard  = id_valid && ex_valid && (ex_ctrl.opcode == op_load) &&
                  (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage
    import rv32i_types::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [31:0]       id_instr,
    input  rv32i_control_word id_ctrl,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output rv32i_control_word ex_ctrl,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [31:0]       bubble_count
);

    id_ex_t      ex_q;
    id_ex_t      id_next;
    logic        ex_valid_q;
    logic [31:0] bubble_cnt_q;
    logic        hazard;

    // Assemble what ID would hand to EX this cycle.
    always_comb begin
        id_next          = '0;
        id_next.pc       = id_pc;
        id_next.ctrl     = id_ctrl;
        id_next.rs1      = id_instr[19:15];
        id_next.rs2      = id_instr[24:20];
        id_next.rd       = id_instr[11:7];
        id_next.rs1_data = id_rs1_data;
        id_next.rs2_data = id_rs2_data;
        id_next.imm      = decode_imm(id_instr);
    end

    load_use_detect u_load_use_detect (
        .id_valid (id_valid),
        .id_rs1   (id_instr[19:15]),
        .id_rs2   (id_instr[24:20]),
        .id_ctrl  (id_ctrl),
        .ex_valid (ex_valid_q),
        .ex_ctrl  (ex_q.ctrl),
        .ex_rd    (ex_q.rd),
        .hazard   (hazard)
    );

    // Flush overrides everything; a stalled EX freezes the register, so no bubble is counted then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            ex_q.ctrl  <= '0;
            ex_q.rd    <= '0;
        end else if (ex_stall) begin
            ex_valid_q <= ex_valid_q;
        end else if (hazard) begin
            ex_valid_q   <= 1'b0;
            ex_q.ctrl    <= '0;
            ex_q.rd      <= '0;
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end else if (id_valid) begin
            ex_valid_q <= 1'b1;
            ex_q       <= id_next;
        end else begin
            ex_valid_q <= 1'b0;
            ex_q.ctrl  <= '0;
            ex_q.rd    <= '0;
        end
    end

    // Reset gating keeps id_stall low while the core is held in reset.
    always_comb begin
        id_stall = rst_n && !flush && (ex_stall || hazard);
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_q.pc;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign bubble_count = bubble_cnt_q;

endmodule
